s3_chien_forney: RTL
====================

// Module: s3_chien_forney
// PURPOSE
// - Stage 3 of the RS decoder (2t=4, GF(2^8), poly 0x11D, alpha=0x02, syndromes S_j=r(alpha^j), j=0..3).
// - Consumes Lambda(x)=l0+l1x+l2x^2 and Omega(x)=w0+w1x from the KES stage on its done pulse.
// - Runs a serial Chien search over positions 0..N-1 and computes Forney error values.
// - Reports up to 2 (position, value) pairs plus a decode-failure flag to the correction stage.
// PARAMETERS
// N  255  codeword length in symbols (5..255; shortened codes scan only 0..N-1)
// PORTS
// clk          in   1  clock
// rstn         in   1  asynchronous active-low reset
// chien_ena    in   1  start pulse (driven by kes_done); sampled only in IDLE
// rs_lambda0   in   8  Lambda coeff x^0
// rs_lambda1   in   8  Lambda coeff x^1
// rs_lambda2   in   8  Lambda coeff x^2
// rs_omega0    in   8  Omega coeff x^0
// rs_omega1    in   8  Omega coeff x^1
// err_pos0     out  8  first (lowest) error position
// err_pos1     out  8  second error position
// err_val0     out  8  error value at err_pos0
// err_val1     out  8  error value at err_pos1
// err_cnt      out  2  number of valid pairs (0..2)
// dec_fail     out  1  uncorrectable word
// chien_done   out  1  one-cycle pulse; all result outputs valid from this cycle until next pulse
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, all internal regs 0. Reset mid-scan aborts; no chien_done issued.
// - FSM one-hot IDLE->SCAN->DONE->IDLE. chien_ena ignored outside IDLE (no queueing).
// - IDLE & chien_ena: latch t1=l1, t2=l2, wa=w0, w1, l0; inv=1/l1 (gf2m8_inverse); idx=0;
//   found=0; L = l2!=0 ? 2 : l1!=0 ? 1 : 0.
// - SCAN, per cycle at idx=i: Lambda(alpha^-i)=l0^t1^t2; root if zero.
//   Root -> e=(wa^w1)*inv; store (i,e) in slot found, found++ (saturate 2).
//   Then t1*=0x8E (alpha^-1), t2*=0x47 (alpha^-2), wa*=0x02, idx++.
// - SCAN ends after idx=N-1 -> DONE; DONE registers results, pulses chien_done, -> IDLE.
// - Latency: chien_ena sampled at edge 0 -> chien_done high after edge N+1 (one cycle).
// - dec_fail=1 if: l0==0; or L==2 & l1==0 (repeated root); or found!=L.
// - On dec_fail: err_cnt=0, pos/val outputs 0. Else err_cnt=found; unused slots 0.
// - Slots filled in ascending position order; idx counter 8 bits, never wraps (stops at N-1).
// - Results held stable between chien_done pulses; new chien_ena in the DONE cycle is ignored.
// CONFIGURATION
// - CHIEN_EARLY_STOP_EN defined: SCAN -> DONE at end of any cycle where found (incl. current)==L.
//   Last root at position i -> chien_done after edge i+2. L==0 -> after edge 2.
//   All dec_fail rules unchanged.
// - Undefined: full N-position scan always; fixed latency N+1.
// TESTING
// - l=(01,00,00), w=(00,00) -> err_cnt=0, dec_fail=0, chien_done exactly N+1 cycles after ena.
// - l=(01,01,00), w=(5A,00) -> err_pos0=0, err_val0=5A, err_cnt=1, dec_fail=0.
// - l=(01,02,00), w=(33,00) -> err_pos0=1, err_val0=33, err_cnt=1.
// - l=(01,03,02), w=(03,00) -> pos0=0/val0=01, pos1=1/val1=02, err_cnt=2.
// - l=(00,01,00) or l=(01,00,01) -> dec_fail=1, err_cnt=0, all pos/val=0.
// - rstn low mid-scan then ena l=(01,02,00) -> clean restart; also a second ena while busy is ignored.
// - CHIEN_EARLY_STOP_EN: l=(01,02,00), w=(33,00) -> chien_done after edge 3.
//   With l=(01,00,00) -> chien_done after edge 2.

Source files
------------

// File: rtl/s3_chien_forney_if.sv
// KES-to-correction link for the Chien/Forney stage.
// Carries the Lambda/Omega coefficients in and the error pairs out.
interface s3_chien_forney_if;
  logic       chien_ena;
  logic [7:0] rs_lambda0;
  logic [7:0] rs_lambda1;
  logic [7:0] rs_lambda2;
  logic [7:0] rs_omega0;
  logic [7:0] rs_omega1;
  logic [7:0] err_pos0;
  logic [7:0] err_pos1;
  logic [7:0] err_val0;
  logic [7:0] err_val1;
  logic [1:0] err_cnt;
  logic       dec_fail;
  logic       chien_done;

  modport master (
    output chien_ena, rs_lambda0, rs_lambda1, rs_lambda2, rs_omega0, rs_omega1,
    input  err_pos0, err_pos1, err_val0, err_val1, err_cnt, dec_fail, chien_done
  );

  modport slave (
    input  chien_ena, rs_lambda0, rs_lambda1, rs_lambda2, rs_omega0, rs_omega1,
    output err_pos0, err_pos1, err_val0, err_val1, err_cnt, dec_fail, chien_done
  );
endinterface

// File: rtl/s3_chien_forney.sv
// RS(2t=4, GF(2^8)/0x11D) stage 3: serial Chien search plus Forney error values.
// Latency: chien_done N+1 cycles after chien_ena; CHIEN_EARLY_STOP_EN ends the scan at the last expected root.
// Backpressure: none; chien_ena is accepted only while idle, results hold until the next chien_done.
module s3_chien_forney #(
  parameter int N = 255
) (
  input  logic              clk,
  input  logic              rstn,
  s3_chien_forney_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    SCAN = 3'b010,
    DONE = 3'b100
  } state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a240;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a6   = gf_mul(a3, a3);
    a12  = gf_mul(a6, a6);
    a15  = gf_mul(a12, a3);
    a240 = a15;
    for (int k = 0; k < 4; k++) a240 = gf_mul(a240, a240);
    return gf_mul(gf_mul(a240, a12), a2);
  endfunction

  state_t     r_state;
  logic [7:0] r_t1, r_t2, r_wa, r_w1, r_l0, r_inv, r_idx;
  logic [1:0] r_found, r_lcnt;
  logic [7:0] r_pos0, r_pos1, r_val0, r_val1;
  logic [7:0] r_err_pos0, r_err_pos1, r_err_val0, r_err_val1;
  logic [1:0] r_err_cnt;
  logic       r_dec_fail, r_done;

  logic       w_root, w_stop, w_last, w_fail;
  logic [7:0] w_e;
  logic [1:0] w_found_nxt, w_lcnt_in;

  always_comb begin
    w_root      = ((r_l0 ^ r_t1 ^ r_t2) == 8'h00);
    w_e         = gf_mul(r_wa ^ r_w1, r_inv);
    w_found_nxt = (w_root && (r_found != 2'd2)) ? r_found + 2'd1 : r_found;
    w_last      = (r_idx == 8'(N - 1));
`ifdef CHIEN_EARLY_STOP_EN
    w_stop      = w_last || (w_found_nxt == r_lcnt);
`else
    w_stop      = w_last;
`endif
    // t1 only ever scales by nonzero constants, so it still flags l1 == 0.
    w_fail      = (r_l0 == 8'h00) || ((r_lcnt == 2'd2) && (r_t1 == 8'h00)) ||
                  (r_found != r_lcnt);
    w_lcnt_in   = (bus.rs_lambda2 != 8'h00) ? 2'd2 :
                  (bus.rs_lambda1 != 8'h00) ? 2'd1 : 2'd0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_t1       <= 8'h00;
      r_t2       <= 8'h00;
      r_wa       <= 8'h00;
      r_w1       <= 8'h00;
      r_l0       <= 8'h00;
      r_inv      <= 8'h00;
      r_idx      <= 8'h00;
      r_found    <= 2'd0;
      r_lcnt     <= 2'd0;
      r_pos0     <= 8'h00;
      r_pos1     <= 8'h00;
      r_val0     <= 8'h00;
      r_val1     <= 8'h00;
      r_err_pos0 <= 8'h00;
      r_err_pos1 <= 8'h00;
      r_err_val0 <= 8'h00;
      r_err_val1 <= 8'h00;
      r_err_cnt  <= 2'd0;
      r_dec_fail <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.chien_ena) begin
            r_t1    <= bus.rs_lambda1;
            r_t2    <= bus.rs_lambda2;
            r_wa    <= bus.rs_omega0;
            r_w1    <= bus.rs_omega1;
            r_l0    <= bus.rs_lambda0;
            r_inv   <= gf_inv(bus.rs_lambda1);
            r_idx   <= 8'h00;
            r_found <= 2'd0;
            r_lcnt  <= w_lcnt_in;
            r_pos0  <= 8'h00;
            r_pos1  <= 8'h00;
            r_val0  <= 8'h00;
            r_val1  <= 8'h00;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (w_root && (r_found == 2'd0)) begin
            r_pos0 <= r_idx;
            r_val0 <= w_e;
          end else if (w_root && (r_found == 2'd1)) begin
            r_pos1 <= r_idx;
            r_val1 <= w_e;
          end
          r_found <= w_found_nxt;
          // Step to the next position: x = alpha^-(i+1), Omega's x^0 term rescaled by alpha.
          r_t1    <= gf_mul(r_t1, 8'h8E);
          r_t2    <= gf_mul(r_t2, 8'h47);
          r_wa    <= gf_mul(r_wa, 8'h02);
          if (w_stop) r_state <= DONE;
          else        r_idx   <= r_idx + 8'd1;
        end
        DONE: begin
          r_dec_fail <= w_fail;
          r_err_cnt  <= w_fail ? 2'd0  : r_found;
          r_err_pos0 <= w_fail ? 8'h00 : r_pos0;
          r_err_pos1 <= w_fail ? 8'h00 : r_pos1;
          r_err_val0 <= w_fail ? 8'h00 : r_val0;
          r_err_val1 <= w_fail ? 8'h00 : r_val1;
          r_done     <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.err_pos0   = r_err_pos0;
  assign bus.err_pos1   = r_err_pos1;
  assign bus.err_val0   = r_err_val0;
  assign bus.err_val1   = r_err_val1;
  assign bus.err_cnt    = r_err_cnt;
  assign bus.dec_fail   = r_dec_fail;
  assign bus.chien_done = r_done;

endmodule
